// File: rtl/button_pkg.sv
// Shared definitions for the button gesture path (debouncer + classifier).
// Holds the classifier state encoding and the default timing constants
// so the debouncer depth and the classifier windows stay in one place.
package button_pkg;

  localparam int LONG_CYC_DEF = 8;  // high samples that make a long press
  localparam int GAP_CYC_DEF  = 4;  // low samples that close the double window
  localparam int CW_DEF       = 8;  // duration counter width

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_PRESSED1  = 3'd1,
    ST_WAIT_GAP  = 3'd2,
    ST_PRESSED2  = 3'd3,
    ST_LONG_HELD = 3'd4
  } state_e;

endpackage

// File: rtl/button_press_classifier.sv
// Classifies debounced button gestures into short, long and double presses.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// IDLE      | waiting for a rising edge on btn_in
// PRESSED1  | first press in progress, cnt = high samples so far
// WAIT_GAP  | first press released, cnt = low samples so far
// PRESSED2  | second press in progress, duration ignored
// LONG_HELD | long press already reported, waiting for release
//
// Ports:
//   clk          in   single clock, posedge
//   rst_n        in   synchronous active-low reset
//   btn_in       in   debounced button level
//   short_press  out  one-cycle pulse, single short press
//   long_press   out  one-cycle pulse, hold reached LONG_CYC samples
//   double_press out  one-cycle pulse, second press completed in window
//   held         out  level, high while in LONG_HELD
//   busy         out  level, high whenever state is not IDLE
module button_press_classifier
  import button_pkg::*;
#(
  parameter int LONG_CYC = LONG_CYC_DEF,
  parameter int GAP_CYC  = GAP_CYC_DEF,
  parameter int CW       = CW_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_in,
  output logic short_press,
  output logic long_press,
  output logic double_press,
  output logic held,
  output logic busy
);

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          btn_q;
  logic          short_q, short_d;
  logic          long_q, long_d;
  logic          double_q, double_d;
  logic          held_q, held_d;
  logic          busy_q, busy_d;
  logic          rise;

  assign rise = btn_in & ~btn_q;

  // Next-state and next-output logic.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    short_d  = 1'b0;
    long_d   = 1'b0;
    double_d = 1'b0;

    case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (rise) begin
          state_d = ST_PRESSED1;
          cnt_d   = CW'(1);
        end
      end

      ST_PRESSED1: begin
        if (btn_in) begin
          if (cnt_q == CW'(LONG_CYC - 1)) begin
            state_d = ST_LONG_HELD;
            long_d  = 1'b1;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end else begin
          state_d = ST_WAIT_GAP;
          cnt_d   = CW'(1);
        end
      end

      ST_WAIT_GAP: begin
        // cnt holds the low samples already seen; the current low sample
        // is number cnt+1, so the window closes when that reaches GAP_CYC.
        // The release sample was taken in PRESSED1, so it can never close
        // the window on its own edge even when GAP_CYC is 1.
        if (btn_in) begin
          state_d = ST_PRESSED2;
          cnt_d   = '0;
        end else if (cnt_q >= CW'(GAP_CYC - 1)) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
          short_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      ST_PRESSED2: begin
        cnt_d = '0;
        if (!btn_in) begin
          state_d  = ST_IDLE;
          double_d = 1'b1;
        end
      end

      ST_LONG_HELD: begin
        cnt_d = '0;
        if (!btn_in) state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase

    held_d = (state_d == ST_LONG_HELD);
    busy_d = (state_d != ST_IDLE);
  end

  // State, counter and edge register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      // Pretend the button was high so a press held through reset
      // produces no rise until it is released and pressed again.
      btn_q   <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      btn_q   <= btn_in;
    end
  end

  // Registered outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      short_q  <= 1'b0;
      long_q   <= 1'b0;
      double_q <= 1'b0;
      held_q   <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      short_q  <= short_d;
      long_q   <= long_d;
      double_q <= double_d;
      held_q   <= held_d;
      busy_q   <= busy_d;
    end
  end

  assign short_press  = short_q;
  assign long_press   = long_q;
  assign double_press = double_q;
  assign held         = held_q;
  assign busy         = busy_q;

endmodule

// File: tb/tb_button_press_classifier.sv
// Self-checking bench for button_press_classifier (LONG_CYC=8, GAP_CYC=4).
// Expected pulses are queued as {edge number, one-hot kind}; a negedge
// monitor pops and compares them when the DUT pulses.
module tb_button_press_classifier;

  logic clk = 1'b0;
  logic rst_n;
  logic btn_in;
  logic short_press, long_press, double_press, held, busy;

  always #5 clk = ~clk;

  button_press_classifier #(.LONG_CYC(8), .GAP_CYC(4), .CW(8)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .btn_in       (btn_in),
    .short_press  (short_press),
    .long_press   (long_press),
    .double_press (double_press),
    .held         (held),
    .busy         (busy)
  );

  localparam logic [2:0] K_SHORT  = 3'b001;
  localparam logic [2:0] K_LONG   = 3'b010;
  localparam logic [2:0] K_DOUBLE = 3'b100;

  typedef struct {
    int         cyc;
    logic [2:0] kind;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  logic mon_en = 1'b0;

  // Drive one edge's worth of inputs, then return at the following negedge.
  task automatic step(input logic b, input logic r);
    btn_in = b;
    rst_n  = r;
    @(posedge clk);
    cyc++;
    @(negedge clk);
  endtask

  task automatic do_reset();
    mon_en = 1'b0;
    sb.delete();
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    cyc = 0;
  endtask

  // Scoreboard monitor: pops one expectation per observed pulse.
  always @(negedge clk) begin
    logic [2:0] pv;
    exp_t       e;
    if (mon_en) begin
      pv = {double_press, long_press, short_press};
      while (sb.size() > 0 && sb[0].cyc < cyc) begin
        total++;
        bad++;
        $display("FAIL missed_pulse: at edge %0d no pulse seen, wanted kind %b after edge %0d",
                 cyc, sb[0].kind, sb[0].cyc);
        void'(sb.pop_front());
      end
      if (pv != 3'b000) begin
        total++;
        if (sb.size() == 0) begin
          bad++;
          $display("FAIL unexpected_pulse: got kind %b after edge %0d, wanted none", pv, cyc);
        end else begin
          e = sb.pop_front();
          if (e.cyc !== cyc || e.kind !== pv) begin
            bad++;
            $display("FAIL pulse: got kind %b after edge %0d, wanted kind %b after edge %0d",
                     pv, cyc, e.kind, e.cyc);
          end
        end
      end
    end
  end

  task automatic finish_scenario(input string name);
    total++;
    if (sb.size() !== 0) begin
      bad++;
      $display("FAIL %s_leftover: %0d expected pulses never seen, wanted 0", name, sb.size());
    end
    mon_en = 1'b0;
  endtask

  task automatic test_reset();
    logic [4:0] o;
    for (int k = 0; k < 3; k++) step(1'b1, 1'b0);
    o = {short_press, long_press, double_press, held, busy};
    total++;
    if (o !== 5'b0) begin
      bad++;
      $display("FAIL reset_outputs: got %b wanted 00000", o);
    end
    // Button held through reset release must not count as a press.
    cyc = 0;
    sb.delete();
    mon_en = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      step(1'b1, 1'b1);
      total++;
      if (busy !== 1'b0) begin
        bad++;
        $display("FAIL reset_held_busy: edge %0d got %b wanted 0", k, busy);
      end
    end
    for (int k = 7; k <= 10; k++) step(1'b0, 1'b1);
    finish_scenario("reset");
  endtask

  task automatic test_short();
    do_reset();
    sb.push_back('{8, K_SHORT});
    mon_en = 1'b1;
    for (int k = 1; k <= 14; k++) begin
      step(k >= 2 && k <= 4, 1'b1);
      if (k >= 2 && k <= 7) begin
        total++;
        if (busy !== 1'b1) begin
          bad++;
          $display("FAIL short_busy: edge %0d got %b wanted 1", k, busy);
        end
      end
      if (k == 1 || k >= 9) begin
        total++;
        if (busy !== 1'b0) begin
          bad++;
          $display("FAIL short_idle: edge %0d got %b wanted 0", k, busy);
        end
      end
    end
    finish_scenario("short");
  endtask

  task automatic test_long();
    logic exp_h;
    do_reset();
    sb.push_back('{9, K_LONG});
    mon_en = 1'b1;
    for (int k = 1; k <= 22; k++) begin
      step(k >= 2 && k <= 14, 1'b1);
      exp_h = (k >= 9 && k <= 14);
      total++;
      if (held !== exp_h) begin
        bad++;
        $display("FAIL long_held: edge %0d got %b wanted %b", k, held, exp_h);
      end
    end
    finish_scenario("long");
  endtask

  task automatic test_double();
    do_reset();
    sb.push_back('{8, K_DOUBLE});
    mon_en = 1'b1;
    for (int k = 1; k <= 16; k++)
      step((k >= 2 && k <= 3) || (k >= 6 && k <= 7), 1'b1);
    finish_scenario("double");
  endtask

  task automatic test_window_expiry();
    do_reset();
    sb.push_back('{7, K_SHORT});
    sb.push_back('{13, K_SHORT});
    mon_en = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      step((k >= 2 && k <= 3) || (k >= 8 && k <= 9), 1'b1);
      if (k == 7) begin
        total++;
        if (busy !== 1'b0) begin
          bad++;
          $display("FAIL expiry_busy: edge %0d got %b wanted 0", k, busy);
        end
      end
    end
    finish_scenario("expiry");
  endtask

  task automatic test_reset_mid_press();
    logic [4:0] o;
    do_reset();
    sb.push_back('{30, K_SHORT});
    mon_en = 1'b1;
    for (int k = 1; k <= 36; k++) begin
      step((k >= 2 && k <= 20) || (k >= 25 && k <= 26), !(k == 5 || k == 6));
      if (k >= 5 && k <= 24) begin
        o = {short_press, long_press, double_press, held, busy};
        total++;
        if (o !== 5'b0) begin
          bad++;
          $display("FAIL midreset_outputs: edge %0d got %b wanted 00000", k, o);
        end
      end
    end
    finish_scenario("midreset");
  endtask

  task automatic test_long_second();
    do_reset();
    sb.push_back('{25, K_DOUBLE});
    mon_en = 1'b1;
    for (int k = 1; k <= 30; k++) begin
      step((k >= 2 && k <= 3) || (k >= 5 && k <= 24), 1'b1);
      if (k >= 5 && k <= 24) begin
        total++;
        if (held !== 1'b0 || busy !== 1'b1) begin
          bad++;
          $display("FAIL second_long: edge %0d got held=%b busy=%b wanted held=0 busy=1",
                   k, held, busy);
        end
      end
    end
    finish_scenario("second_long");
  endtask

  task automatic test_back_to_back();
    // Short press whose pulse cycle coincides with a new rise, then a
    // long press immediately after.
    do_reset();
    sb.push_back('{7, K_SHORT});
    sb.push_back('{15, K_LONG});
    mon_en = 1'b1;
    for (int k = 1; k <= 20; k++)
      step((k >= 2 && k <= 3) || (k >= 8 && k <= 17), 1'b1);
    finish_scenario("b2b");
  endtask

  initial begin
    btn_in = 1'b0;
    rst_n  = 1'b0;
    test_reset();
    test_short();
    test_long();
    test_double();
    test_window_expiry();
    test_reset_mid_press();
    test_long_second();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
